// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Request/grant bundle between requesters and the round-robin
//               mux arbiter.
//               req       - per-requester level request (master drives)
//               sel       - registered mux select of current owner
//               gnt       - registered one-hot grant, zero when idle
//               gnt_valid - gnt holds a valid owner
//               hold_cnt  - cycles already spent by current owner (0-based)
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int N    = 8,
    parameter int SELW = 3
);
    logic [N-1:0]    req;
    logic [SELW-1:0] sel;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [SELW-1:0] hold_cnt;

    // Requester side drives requests and observes the grant.
    modport master (
        output req,
        input  sel,
        input  gnt,
        input  gnt_valid,
        input  hold_cnt
    );

    // Arbiter side.
    modport slave (
        input  req,
        output sel,
        output gnt,
        output gnt_valid,
        output hold_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing one N:1 mux among N requesters.
//               Every output is registered. An owner keeps the grant for at
//               most MAX_HOLD consecutive cycles, then hands over directly to
//               the next pending requester (no idle bubble).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - mux_rr_arbiter_if.slave (req in; sel, gnt,
//                       gnt_valid, hold_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int N        = 8,
    parameter int SELW     = 3,
    parameter int MAX_HOLD = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux_rr_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [SELW-1:0] c_hold_last = SELW'(MAX_HOLD - 1);
    localparam logic [SELW-1:0] c_ptr_init  = SELW'(N - 1);

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [SELW-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]    search_mask;
    logic [SELW-1:0] cand;
    logic            cand_found;
    logic            owner_req;
    logic [SELW-1:0] idx;

    // While granted, the owner's own bit is masked so the search only finds
    // other requesters; ptr equals the owner then, so one search serves
    // both the idle and the hand-over cases.
    always_comb begin
        search_mask = (state_q == ST_GRANT) ? (bus.req & ~gnt_q) : bus.req;
        owner_req   = |(bus.req & gnt_q);
        cand        = '0;
        cand_found  = 1'b0;
        idx         = '0;
        // Scan ptr+1, ptr+2, ... ; SELW-bit addition wraps modulo N.
        for (int k = 1; k <= N; k++) begin
            idx = ptr_q + SELW'(k);
            if (!cand_found && search_mask[idx]) begin
                cand       = idx;
                cand_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cand_found) begin
                    state_d     = ST_GRANT;
                    sel_d       = cand;
                    gnt_d       = N'(1) << cand;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    ptr_d       = cand;
                end
            end
            ST_GRANT: begin
                if (owner_req && (hold_cnt_q != c_hold_last)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (cand_found) begin
                    sel_d       = cand;
                    gnt_d       = N'(1) << cand;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    ptr_d       = cand;
                end else if (owner_req) begin
                    // Tenure expired with nobody else waiting: re-grant.
                    hold_cnt_d = '0;
                end else begin
                    // sel deliberately keeps the last owner's index.
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= c_ptr_init;
            sel_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.hold_cnt  = hold_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Directed self-checking bench for mux_rr_arbiter. Inputs are
//               driven 1 ns after each rising edge and outputs are sampled
//               at the same point, after the edge has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int N        = 8;
    localparam int SELW     = 3;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_rr_arbiter_if #(.N(N), .SELW(SELW)) bus ();

    mux_rr_arbiter #(
        .N        (N),
        .SELW     (SELW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_owner(input string tag, input int owner, input int hold);
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        exp_gnt[owner] = 1'b1;
        check({tag, ".gnt"},       32'(bus.gnt),       32'(exp_gnt));
        check({tag, ".sel"},       32'(bus.sel),       32'(owner));
        check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'd1);
        check({tag, ".hold_cnt"},  32'(bus.hold_cnt),  32'(hold));
    endtask

    task automatic check_idle(input string tag, input int sel_exp);
        check({tag, ".gnt"},       32'(bus.gnt),       32'd0);
        check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'd0);
        check({tag, ".sel"},       32'(bus.sel),       32'(sel_exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then idle with no requests.
        bus.req = '0;
        rst_n   = 1'b0;
        repeat (2) tick();
        check_idle("reset", 0);
        check("reset.hold_cnt", 32'(bus.hold_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("idle_no_req", 0);

        // Single requester 3: re-granted on expiry, grant never drops.
        bus.req = 8'h08;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_owner("single", 3, i % MAX_HOLD);
            tick();
        end
        bus.req = 8'h00;
        tick();
        check_idle("single_drop", 3);

        // All requesting from reset: 0..7,0 each for MAX_HOLD cycles.
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 36; c++) begin
            check_owner("all_rr", (c / MAX_HOLD) % N, c % MAX_HOLD);
            tick();
        end

        // Early release: owner 2 drops at hold_cnt=1 while 6 waits.
        rst_n   = 1'b0;
        bus.req = 8'h04;
        tick();
        rst_n = 1'b1;
        tick();
        check_owner("early_g2", 2, 0);
        tick();
        check_owner("early_h1", 2, 1);
        bus.req = 8'h40;
        tick();
        check_owner("early_sw6", 6, 0);

        // Wrap-around from ptr=6: order 7, 0, 1.
        bus.req = 8'h83;
        tick();
        for (int c = 0; c < 9; c++) begin
            check_owner("wrap", (c < 4) ? 7 : ((c < 8) ? 0 : 1), c % MAX_HOLD);
            tick();
        end

        // Hand over to 4, then drop to idle; sel must keep 4.
        bus.req = 8'h10;
        tick();
        check_owner("to4", 4, 0);
        bus.req = 8'h00;
        tick();
        check_idle("drop_idle", 4);
        tick();
        check_idle("drop_idle2", 4);
        bus.req = 8'h10;
        check_idle("pre_regrant", 4);
        tick();
        check_owner("regrant4", 4, 0);

        // Asynchronous reset while owner 5 holds the grant.
        bus.req = 8'h20;
        tick();
        check_owner("own5", 5, 0);
        tick();
        check_owner("own5_h1", 5, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst", 0);
        check("async_rst.hold_cnt", 32'(bus.hold_cnt), 32'd0);
        bus.req = 8'h00;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_idle("post_rst", 0);
        check("post_rst.hold_cnt", 32'(bus.hold_cnt), 32'd0);

        // Re-arbitration restarts at requester 0; prior owner 5 gets no priority.
        bus.req = 8'h21;
        tick();
        check_owner("rearb0", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
